// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: inter-stage bundles,
// load-op bit positions and derived bus widths.
package mem_stage_pkg;

    localparam int LD_B  = 0;
    localparam int LD_BU = 1;
    localparam int LD_H  = 2;
    localparam int LD_HU = 3;
    localparam int LD_W  = 4;

    localparam int ST_B = 0;
    localparam int ST_H = 1;
    localparam int ST_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  ld_op;
        logic [2:0]  st_op;
        logic        ertn;
        logic [4:0]  dest;
        logic        gr_we;
        logic        res_from_mem;
        logic        res_from_cnt;
        logic        res_from_csr;
        logic [1:0]  addr_lo;
        logic [3:0]  mul_div_op;
        logic        mul_div_sign;
        logic [31:0] alu_result;
        logic [31:0] timer;
        logic        excp;
        logic [5:0]  excp_num;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
    } es_to_ms_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        ertn;
        logic [4:0]  dest;
        logic        gr_we;
        logic        res_from_csr;
        logic [31:0] final_result;
        logic        excp;
        logic [5:0]  excp_num;
        logic [31:0] err_addr;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
    } ms_to_ws_t;

    typedef struct packed {
        logic        ms_valid;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic        res_from_csr;
        logic        data_pending;
    } ms_forward_t;

    localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
    localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);
    localparam int MS_FORWARD_WD   = $bits(ms_forward_t);

endpackage

// File: rtl/mem_stage_if.sv
// Data-SRAM channel as seen by the memory stage.
// master drives req/addr_ok/data_ok/rdata; slave (mem_stage) observes.
interface mem_stage_if;

    logic        data_sram_req;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req,
        output data_sram_addr_ok,
        output data_sram_data_ok,
        output data_sram_rdata
    );

    modport slave (
        input data_sram_req,
        input data_sram_addr_ok,
        input data_sram_data_ok,
        input data_sram_rdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks byte/half/word by addr_lo, sign/zero-extends.
// Ports: ld_op (one-hot), addr_lo, rdata in; result out. Combinational.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  ld_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        unique case (1'b1)
            ld_op[LD_B]:  result = {{24{byte_sel[7]}}, byte_sel};
            ld_op[LD_BU]: result = {24'b0, byte_sel};
            ld_op[LD_H]:  result = {{16{half_sel[15]}}, half_sel};
            ld_op[LD_HU]: result = {16'b0, half_sel};
            default:      result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: waits for data_ok, aligns loads, selects results.
// Ports: clk/reset, es/ws handshakes, forward bus, ms_ex, SRAM channel, mul/div, flushes.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FORWARD_WD-1:0]   ms_forward,
    output logic                       ms_ex,
    mem_stage_if.slave                 sram,
    input  logic [63:0]                mul_result,
    input  logic [31:0]                div_quotient,
    input  logic [31:0]                div_remainder,
    input  logic                       excp_flush,
    input  logic                       ertn_flush
);

    es_to_ms_t   ms_bus;
    ms_to_ws_t   ws_bus;
    ms_forward_t fwd_bus;

    logic        ms_valid;
    logic [1:0]  inflight;
    logic [1:0]  inflight_nxt;
    logic [1:0]  discard;
    logic        buf_valid;
    logic [31:0] data_buf;

    logic        flush;
    logic        mem_op;
    logic        mem_wait;
    logic        live_ok;
    logic        ms_ready_go;
    logic        accepted;
    logic        leave;
    logic        capture;
    logic [31:0] mem_rdata;
    logic [31:0] ld_result;
    logic [31:0] md_result;
    logic [31:0] final_result;
    logic        unused_bits;

    assign flush    = excp_flush | ertn_flush;
    assign mem_op   = (|ms_bus.ld_op) | (|ms_bus.st_op);
    assign mem_wait = ms_valid & mem_op & ~ms_bus.excp;
    // A response is live only once all flushed requests have drained.
    assign live_ok  = sram.data_sram_data_ok & (discard == 2'd0);
    assign accepted = sram.data_sram_req & sram.data_sram_addr_ok;

    assign ms_ready_go    = ~mem_wait | buf_valid | live_ok;
    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin) | flush;
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
    assign leave          = ms_to_ws_valid & ws_allowin;
    assign capture        = live_ok & mem_wait & ~buf_valid
                          & ~ws_allowin & ~flush;

    assign inflight_nxt = inflight
                        + {1'b0, accepted}
                        - {1'b0, sram.data_sram_data_ok};

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid  <= 1'b0;
            ms_bus    <= '0;
            inflight  <= 2'd0;
            discard   <= 2'd0;
            buf_valid <= 1'b0;
            data_buf  <= 32'd0;
        end else begin
            if (flush)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;

            if (es_to_ms_valid & ms_allowin)
                ms_bus <= es_to_ms_t'(es_to_ms_bus);

            inflight <= inflight_nxt;

            // Everything still outstanding after this cycle belongs to
            // squashed instructions and must be swallowed.
            if (flush)
                discard <= inflight_nxt;
            else if (sram.data_sram_data_ok && discard != 2'd0)
                discard <= discard - 2'd1;

            if (flush | leave) begin
                buf_valid <= 1'b0;
            end else if (capture) begin
                buf_valid <= 1'b1;
                data_buf  <= sram.data_sram_rdata;
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(sram.data_sram_data_ok && inflight == 2'd0));
    assert property (@(posedge clk) disable iff (reset)
        !(inflight == 2'd2 && accepted && !sram.data_sram_data_ok));

    assign mem_rdata = buf_valid ? data_buf : sram.data_sram_rdata;

    mem_stage_load_align u_align (
        .ld_op   (ms_bus.ld_op),
        .addr_lo (ms_bus.addr_lo),
        .rdata   (mem_rdata),
        .result  (ld_result)
    );

    always_comb begin
        md_result = ms_bus.alu_result;
        unique case (1'b1)
            ms_bus.mul_div_op[0]: md_result = mul_result[31:0];
            ms_bus.mul_div_op[1]: md_result = mul_result[63:32];
            ms_bus.mul_div_op[2]: md_result = div_quotient;
            ms_bus.mul_div_op[3]: md_result = div_remainder;
            default:              md_result = ms_bus.alu_result;
        endcase
    end

    always_comb begin
        if (ms_bus.res_from_mem)
            final_result = ld_result;
        else if (ms_bus.res_from_cnt)
            final_result = ms_bus.timer;
        else
            final_result = md_result;
    end

    always_comb begin
        ws_bus              = '0;
        ws_bus.pc           = ms_bus.pc;
        ws_bus.ertn         = ms_bus.ertn;
        ws_bus.dest         = ms_bus.dest;
        ws_bus.gr_we        = ms_bus.gr_we;
        ws_bus.res_from_csr = ms_bus.res_from_csr;
        ws_bus.final_result = final_result;
        ws_bus.excp         = ms_bus.excp;
        ws_bus.excp_num     = ms_bus.excp_num;
        ws_bus.err_addr     = ms_bus.alu_result;
        ws_bus.csr_we       = ms_bus.csr_we;
        ws_bus.csr_num      = ms_bus.csr_num;
        ws_bus.csr_wmask    = ms_bus.csr_wmask;
        ws_bus.csr_wvalue   = ms_bus.csr_wvalue;
    end

    always_comb begin
        fwd_bus              = '0;
        fwd_bus.ms_valid     = ms_valid;
        fwd_bus.gr_we        = ms_bus.gr_we;
        fwd_bus.dest         = ms_bus.dest;
        fwd_bus.final_result = final_result;
        fwd_bus.res_from_csr = ms_bus.res_from_csr;
        // Load value not yet available: decode has to stall.
        fwd_bus.data_pending = ms_valid & ms_bus.res_from_mem & mem_wait
                             & ~buf_valid & ~live_ok;
    end

    assign ms_to_ws_bus = ws_bus;
    assign ms_forward   = fwd_bus;
    assign ms_ex        = ms_valid & (ms_bus.excp | ms_bus.ertn);
    assign unused_bits  = ms_bus.mul_div_sign;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random
// instructions checked against a behavioural result/timing model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic ws_allowin;
    logic ms_allowin;
    logic es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_FORWARD_WD-1:0]   ms_forward;
    logic ms_ex;
    logic [63:0] mul_result;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic excp_flush;
    logic ertn_flush;

    ms_to_ws_t   wsb;
    ms_forward_t fwd;
    assign wsb = ms_to_ws_t'(ms_to_ws_bus);
    assign fwd = ms_forward_t'(ms_forward);

    mem_stage_if sram();

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ws_allowin     (ws_allowin),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_forward     (ms_forward),
        .ms_ex          (ms_ex),
        .sram           (sram),
        .mul_result     (mul_result),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder),
        .excp_flush     (excp_flush),
        .ertn_flush     (ertn_flush)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result the writeback stage must see, from the architectural rules.
    function automatic logic [31:0] model(es_to_ms_t b, logic [31:0] rd,
                                          logic [63:0] mul, logic [31:0] q,
                                          logic [31:0] r);
        int a;
        int v;
        a = int'(b.addr_lo);
        if (b.res_from_mem) begin
            if (b.ld_op[LD_W]) return rd;
            if (b.ld_op[LD_B] || b.ld_op[LD_BU]) begin
                v = int'((rd >> (8 * a)) % 256);
                if (b.ld_op[LD_B] && v >= 128) v -= 256;
                return v;
            end
            v = int'((rd >> (16 * (a / 2))) % 65536);
            if (b.ld_op[LD_H] && v >= 32768) v -= 65536;
            return v;
        end
        if (b.res_from_cnt) return b.timer;
        if (b.mul_div_op[0]) return mul[31:0];
        if (b.mul_div_op[1]) return mul[63:32];
        if (b.mul_div_op[2]) return q;
        if (b.mul_div_op[3]) return r;
        return b.alu_result;
    endfunction

    function automatic es_to_ms_t mk_ld(int op, logic [31:0] addr);
        es_to_ms_t b = '0;
        b.pc           = 32'h1c00_0000;
        b.ld_op        = 5'(1 << op);
        b.res_from_mem = 1'b1;
        b.gr_we        = 1'b1;
        b.dest         = 5'd4;
        b.alu_result   = addr;
        b.addr_lo      = addr[1:0];
        return b;
    endfunction

    function automatic es_to_ms_t rand_instr();
        es_to_ms_t b = '0;
        int kind;
        kind         = int'($urandom_range(0, 6));
        b.pc         = $urandom;
        b.alu_result = $urandom;
        b.addr_lo    = b.alu_result[1:0];
        b.timer      = $urandom;
        b.dest       = 5'($urandom);
        b.csr_num    = 14'($urandom);
        b.csr_wmask  = $urandom;
        b.csr_wvalue = $urandom;
        b.excp       = ($urandom_range(0, 7) == 0);
        b.excp_num   = 6'($urandom);
        case (kind)
            0: begin
                b.ld_op        = 5'(1 << $urandom_range(0, 4));
                b.res_from_mem = 1'b1;
                b.gr_we        = 1'b1;
            end
            1: b.st_op = 3'(1 << $urandom_range(0, 2));
            2: begin
                b.mul_div_op = 4'(1 << $urandom_range(0, 3));
                b.gr_we      = 1'b1;
            end
            3: begin
                b.res_from_cnt = 1'b1;
                b.gr_we        = 1'b1;
            end
            4: begin
                b.res_from_csr = 1'b1;
                b.csr_we       = 1'b1;
            end
            5: b.ertn = 1'b1;
            default: b.gr_we = 1'b1;
        endcase
        return b;
    endfunction

    // One instruction through an otherwise empty stage. ws_low < 0 means
    // random back-pressure, else ws_allowin stays low for ws_low cycles.
    task automatic run_instr(input es_to_ms_t b, input int lat,
                             input logic [31:0] rd, input int ws_low,
                             input logic [63:0] mul, input logic [31:0] q,
                             input logic [31:0] r, output logic [31:0] got);
        logic wt;
        logic load;
        logic [31:0] exp;
        bit done;
        done          = 0;
        got           = '0;
        wt            = ((b.ld_op != 0) || (b.st_op != 0)) && !b.excp;
        load          = wt && b.res_from_mem;
        exp           = model(b, rd, mul, q, r);
        mul_result    = mul;
        div_quotient  = q;
        div_remainder = r;

        es_to_ms_valid         = 1'b1;
        es_to_ms_bus           = b;
        sram.data_sram_req     = wt;
        sram.data_sram_addr_ok = wt;
        ws_allowin             = 1'b1;
        #1;
        expect_eq("entry_allowin", 32'(ms_allowin), 32'd1);
        tick();
        es_to_ms_valid         = 1'b0;
        sram.data_sram_req     = 1'b0;
        sram.data_sram_addr_ok = 1'b0;

        for (int k = 1; k <= 24 && !done; k++) begin
            logic ws;
            logic ev;
            sram.data_sram_data_ok = wt && (k == lat);
            sram.data_sram_rdata   = (k == lat) ? rd : $urandom;
            ws = (ws_low < 0) ? ($urandom_range(0, 2) != 0) : (k > ws_low);
            ws_allowin = ws;
            ev = !wt || (k >= lat);
            #1;
            expect_eq("ws_valid", 32'(ms_to_ws_valid), 32'(ev));
            expect_eq("pending", 32'(fwd.data_pending), 32'(load && k < lat));
            expect_eq("ms_ex", 32'(ms_ex), 32'(b.excp || b.ertn));
            expect_eq("allowin", 32'(ms_allowin), 32'(ev && ws));
            if (ms_to_ws_valid && ws) begin
                got = wsb.final_result;
                if (!b.excp) begin
                    expect_eq("result", wsb.final_result, exp);
                    expect_eq("fwd_result", fwd.final_result, exp);
                end
                expect_eq("err_addr", wsb.err_addr, b.alu_result);
                expect_eq("excp_num", 32'(wsb.excp_num), 32'(b.excp_num));
                expect_eq("pc", wsb.pc, b.pc);
                expect_eq("dest", 32'(fwd.dest), 32'(b.dest));
                done = 1;
            end
            tick();
        end
        sram.data_sram_data_ok = 1'b0;
        if (!done) expect_eq("timeout", 32'd0, 32'd1);
        #1;
        expect_eq("no_dup", 32'(ms_to_ws_valid), 32'd0);
        expect_eq("fwd_drained", 32'(fwd.ms_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        es_to_ms_t   b;
        es_to_ms_t   b2;
        logic [31:0] got;

        reset                  = 1'b1;
        ws_allowin             = 1'b1;
        es_to_ms_valid         = 1'b0;
        es_to_ms_bus           = '0;
        mul_result             = '0;
        div_quotient           = '0;
        div_remainder          = '0;
        excp_flush             = 1'b0;
        ertn_flush             = 1'b0;
        sram.data_sram_req     = 1'b0;
        sram.data_sram_addr_ok = 1'b0;
        sram.data_sram_data_ok = 1'b0;
        sram.data_sram_rdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        expect_eq("rst_ws_valid", 32'(ms_to_ws_valid), 32'd0);
        expect_eq("rst_ms_ex", 32'(ms_ex), 32'd0);
        expect_eq("rst_fwd_valid", 32'(fwd.ms_valid), 32'd0);
        expect_eq("rst_allowin", 32'(ms_allowin), 32'd1);

        // ld_w, response three cycles after entry
        run_instr(mk_ld(LD_W, 32'h1000), 3, 32'hDEADBEEF, 0,
                  64'd0, 32'd0, 32'd0, got);
        expect_eq("ld_w", got, 32'hDEADBEEF);

        run_instr(mk_ld(LD_B, 32'h1003), 2, 32'h80123456, 0,
                  64'd0, 32'd0, 32'd0, got);
        expect_eq("ld_b", got, 32'hFFFFFF80);
        run_instr(mk_ld(LD_BU, 32'h1003), 1, 32'h80123456, 0,
                  64'd0, 32'd0, 32'd0, got);
        expect_eq("ld_bu", got, 32'h00000080);
        run_instr(mk_ld(LD_H, 32'h1002), 2, 32'h80123456, 0,
                  64'd0, 32'd0, 32'd0, got);
        expect_eq("ld_h", got, 32'hFFFF8012);
        run_instr(mk_ld(LD_HU, 32'h1002), 1, 32'h80123456, 0,
                  64'd0, 32'd0, 32'd0, got);
        expect_eq("ld_hu", got, 32'h00008012);

        // response buffered while writeback is blocked
        run_instr(mk_ld(LD_W, 32'h2000), 1, 32'h12345678, 4,
                  64'd0, 32'd0, 32'd0, got);
        expect_eq("buffered", got, 32'h12345678);

        b = '0;
        b.gr_we = 1'b1;
        b.alu_result = 32'h55;
        b.mul_div_op = 4'b0010;
        run_instr(b, 0, 32'd0, 0, 64'h00000001_FFFFFFFE, 32'd7, 32'd3, got);
        expect_eq("mulh", got, 32'h00000001);
        b.mul_div_op = 4'b0001;
        run_instr(b, 0, 32'd0, 0, 64'h00000001_FFFFFFFE, 32'd7, 32'd3, got);
        expect_eq("mull", got, 32'hFFFFFFFE);
        b.mul_div_op = 4'b0100;
        run_instr(b, 0, 32'd0, 0, 64'h00000001_FFFFFFFE, 32'd7, 32'd3, got);
        expect_eq("div_q", got, 32'd7);

        // misaligned store carrying an exception: no wait, ms_ex raised
        b = '0;
        b.st_op = 3'b100;
        b.alu_result = 32'h3001;
        b.excp = 1'b1;
        b.excp_num = 6'h09;
        run_instr(b, 0, 32'd0, 0, 64'd0, 32'd0, 32'd0, got);
        expect_eq("st_excp_err", got, 32'h3001);

        // flush while a load waits; its late response must be dropped
        b = mk_ld(LD_W, 32'h4000);
        es_to_ms_valid         = 1'b1;
        es_to_ms_bus           = b;
        sram.data_sram_req     = 1'b1;
        sram.data_sram_addr_ok = 1'b1;
        ws_allowin             = 1'b1;
        tick();
        es_to_ms_valid         = 1'b0;
        sram.data_sram_req     = 1'b0;
        sram.data_sram_addr_ok = 1'b0;
        #1;
        expect_eq("fl_pending", 32'(fwd.data_pending), 32'd1);
        expect_eq("fl_wait", 32'(ms_to_ws_valid), 32'd0);
        tick();
        excp_flush = 1'b1;
        #1;
        expect_eq("fl_valid", 32'(ms_to_ws_valid), 32'd0);
        expect_eq("fl_allowin", 32'(ms_allowin), 32'd1);
        tick();
        excp_flush = 1'b0;
        b2 = mk_ld(LD_W, 32'h4004);
        es_to_ms_valid         = 1'b1;
        es_to_ms_bus           = b2;
        sram.data_sram_req     = 1'b1;
        sram.data_sram_addr_ok = 1'b1;
        #1;
        expect_eq("fl_killed", 32'(fwd.ms_valid), 32'd0);
        expect_eq("fl_ms_ex", 32'(ms_ex), 32'd0);
        tick();
        es_to_ms_valid         = 1'b0;
        sram.data_sram_req     = 1'b0;
        sram.data_sram_addr_ok = 1'b0;
        sram.data_sram_data_ok = 1'b1;
        sram.data_sram_rdata   = 32'hBAD0BAD0;
        #1;
        expect_eq("stale_valid", 32'(ms_to_ws_valid), 32'd0);
        expect_eq("stale_pending", 32'(fwd.data_pending), 32'd1);
        tick();
        sram.data_sram_data_ok = 1'b0;
        #1;
        expect_eq("stale_hold", 32'(ms_to_ws_valid), 32'd0);
        tick();
        sram.data_sram_data_ok = 1'b1;
        sram.data_sram_rdata   = 32'h0A0B0C0D;
        #1;
        expect_eq("live_valid", 32'(ms_to_ws_valid), 32'd1);
        expect_eq("live_result", wsb.final_result, 32'h0A0B0C0D);
        tick();
        sram.data_sram_data_ok = 1'b0;
        #1;
        expect_eq("live_no_dup", 32'(ms_to_ws_valid), 32'd0);

        repeat (200) begin
            run_instr(rand_instr(), int'($urandom_range(1, 4)), $urandom, -1,
                      {$urandom, $urandom}, $urandom, $urandom, got);
        end

        // reset while a load waits for its response
        b = mk_ld(LD_W, 32'h5000);
        es_to_ms_valid         = 1'b1;
        es_to_ms_bus           = b;
        sram.data_sram_req     = 1'b1;
        sram.data_sram_addr_ok = 1'b1;
        ws_allowin             = 1'b1;
        tick();
        es_to_ms_valid         = 1'b0;
        sram.data_sram_req     = 1'b0;
        sram.data_sram_addr_ok = 1'b0;
        #1;
        expect_eq("mid_pending", 32'(fwd.data_pending), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        expect_eq("mid_rst_valid", 32'(ms_to_ws_valid), 32'd0);
        expect_eq("mid_rst_ms_ex", 32'(ms_ex), 32'd0);
        expect_eq("mid_rst_fwd", 32'(|ms_forward), 32'd0);
        expect_eq("mid_rst_bus", 32'(|ms_to_ws_bus), 32'd0);
        repeat (3) tick();
        expect_eq("mid_rst_idle", 32'(ms_to_ws_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
